// File: rtl/pwm_mixer_n.sv
// N-channel quadrature-encoder level mixer driving a shared-counter PWM engine.
// Each channel: 2-FF sync, debouncer, detent decoder; duties swap only at period boundaries.
module pwm_mixer_n #(
  parameter int NUM_CH     = 3,
  parameter int WIDTH      = 8,
  parameter int DB_LEN     = 4,
  parameter int STEP       = 1,
  parameter int SATURATE   = 1,
  parameter int INIT_LEVEL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        enc_a,
  input  logic [NUM_CH-1:0]        enc_b,
  output logic [NUM_CH*WIDTH-1:0]  level,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, CNT_MAX};
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT_LEVEL);

  logic [WIDTH-1:0]    cnt_reg;
  logic                period_start_reg;
  logic [2*NUM_CH-1:0] db_all;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= cnt_reg + 1'b1;
      period_start_reg <= (cnt_reg == '0);
    end
  end

  assign period_start = period_start_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Bit 2*gi is phase A, bit 2*gi+1 is phase B.
      for (gj = 0; gj < 2; gj++) begin : g_phase
        logic              pin;
        logic [1:0]        sync_reg;
        logic [DB_LEN-2:0] hist_reg;
        logic [DB_LEN-1:0] win;
        logic              db_reg;

        assign pin = (gj == 0) ? enc_a[gi] : enc_b[gi];
        // Window of the last DB_LEN synced samples: stored history plus the current sync output.
        assign win = {hist_reg, sync_reg[1]};

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            sync_reg <= '0;
            hist_reg <= '0;
            db_reg   <= 1'b0;
          end else begin
            sync_reg <= {sync_reg[0], pin};
            hist_reg <= win[DB_LEN-2:0];
            if (&win)
              db_reg <= 1'b1;
            else if (~|win)
              db_reg <= 1'b0;
          end
        end

        assign db_all[2*gi+gj] = db_reg;
      end

      logic             db_a, db_b;
      logic             prev_a_reg, up_reg, dn_reg, pwm_reg;
      logic [WIDTH-1:0] level_reg, level_next, duty_reg;
      logic [WIDTH:0]   sum_ext, diff_ext;

      assign db_a     = db_all[2*gi];
      assign db_b     = db_all[2*gi+1];
      assign sum_ext  = {1'b0, level_reg} + STEP_EXT;
      assign diff_ext = {1'b0, level_reg} - STEP_EXT;

      always_comb begin
        level_next = level_reg;
        if (up_reg) begin
          if (SATURATE != 0 && sum_ext > MAX_EXT)
            level_next = CNT_MAX;
          else
            level_next = sum_ext[WIDTH-1:0];
        end else if (dn_reg) begin
          // A set borrow bit means the subtraction went below zero.
          if (SATURATE != 0 && diff_ext[WIDTH])
            level_next = '0;
          else
            level_next = diff_ext[WIDTH-1:0];
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prev_a_reg <= 1'b0;
          up_reg     <= 1'b0;
          dn_reg     <= 1'b0;
          level_reg  <= INIT_VAL;
          duty_reg   <= '0;
          pwm_reg    <= 1'b0;
        end else begin
          prev_a_reg <= db_a;
          up_reg     <= db_a & ~prev_a_reg & ~db_b;
          dn_reg     <= db_a & ~prev_a_reg & db_b;
          level_reg  <= level_next;
          if (cnt_reg == CNT_MAX)
            duty_reg <= level_reg;
          pwm_reg    <= (cnt_reg < duty_reg);
        end
      end

      assign level[gi*WIDTH +: WIDTH] = level_reg;
      assign pwm_out[gi]              = pwm_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pwm_mixer_n.sv
// Randomised and directed bench for pwm_mixer_n across four parameter sets,
// checked every cycle against a sample-window / period-arithmetic model.
module tb_pwm_mixer_n;

  localparam int ND = 4;
  localparam int C_NCH [ND] = '{3, 2, 1, 5};
  localparam int C_W   [ND] = '{8, 8, 8, 4};
  localparam int C_DB  [ND] = '{4, 4, 4, 2};
  localparam int C_STEP[ND] = '{1, 10, 1, 1};
  localparam int C_SAT [ND] = '{1, 1, 0, 1};
  localparam int C_INIT[ND] = '{0, 250, 255, 3};

  logic        clk = 1'b0;
  logic        rstn [ND];
  logic [15:0] pa [ND];
  logic [15:0] pb [ND];

  logic [23:0] lv0;  logic [2:0] pw0;
  logic [15:0] lv1;  logic [1:0] pw1;
  logic [7:0]  lv2;  logic       pw2;
  logic [19:0] lv3;  logic [4:0] pw3;
  logic [ND-1:0] ps_v;

  always #5 clk = ~clk;

  pwm_mixer_n #(.NUM_CH(3), .WIDTH(8), .DB_LEN(4), .STEP(1), .SATURATE(1), .INIT_LEVEL(0)) u_d0 (
    .clk(clk), .reset(rstn[0]), .enc_a(pa[0][2:0]), .enc_b(pb[0][2:0]),
    .level(lv0), .pwm_out(pw0), .period_start(ps_v[0]));
  pwm_mixer_n #(.NUM_CH(2), .WIDTH(8), .DB_LEN(4), .STEP(10), .SATURATE(1), .INIT_LEVEL(250)) u_d1 (
    .clk(clk), .reset(rstn[1]), .enc_a(pa[1][1:0]), .enc_b(pb[1][1:0]),
    .level(lv1), .pwm_out(pw1), .period_start(ps_v[1]));
  pwm_mixer_n #(.NUM_CH(1), .WIDTH(8), .DB_LEN(4), .STEP(1), .SATURATE(0), .INIT_LEVEL(255)) u_d2 (
    .clk(clk), .reset(rstn[2]), .enc_a(pa[2][0:0]), .enc_b(pb[2][0:0]),
    .level(lv2), .pwm_out(pw2), .period_start(ps_v[2]));
  pwm_mixer_n #(.NUM_CH(5), .WIDTH(4), .DB_LEN(2), .STEP(1), .SATURATE(1), .INIT_LEVEL(3)) u_d3 (
    .clk(clk), .reset(rstn[3]), .enc_a(pa[3][4:0]), .enc_b(pb[3][4:0]),
    .level(lv3), .pwm_out(pw3), .period_start(ps_v[3]));

  int checks = 0;
  int failures = 0;

  // Model state: edges since reset release, per-channel pin sample history
  // (bit k = pin value k edges ago), debounced history, level and duty in effect.
  int       m_n    [ND];
  int       m_lvl  [ND][16];
  int       m_duty [ND][16];
  bit [15:0] m_sa  [ND][16];
  bit [15:0] m_sb  [ND][16];
  bit       m_da   [ND][16];
  bit       m_db   [ND][16];
  bit [3:0] m_ha   [ND][16];
  bit [3:0] m_hb   [ND][16];

  int hi_acc [ND][16];
  int hi_last[ND][16];
  int per_acc [ND];
  int per_last[ND];

  function automatic logic [11:0] get_level(int d, int ch);
    case (d)
      0:       return {4'b0, lv0[ch*8 +: 8]};
      1:       return {4'b0, lv1[ch*8 +: 8]};
      2:       return {4'b0, lv2};
      default: return {8'b0, lv3[ch*4 +: 4]};
    endcase
  endfunction

  function automatic logic get_pwm(int d, int ch);
    case (d)
      0:       return pw0[ch];
      1:       return pw1[ch];
      2:       return pw2;
      default: return pw3[ch];
    endcase
  endfunction

  function automatic int step_level(int d, int l, bit down);
    int mx = (1 << C_W[d]) - 1;
    int v  = down ? l - C_STEP[d] : l + C_STEP[d];
    if (C_SAT[d] != 0) begin
      if (v > mx) v = mx;
      if (v < 0)  v = 0;
    end else begin
      v = (v + mx + 1) % (mx + 1);
    end
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_and_compare(int d);
    int  p = 1 << C_W[d];
    bit  e_ps;
    bit  e_pwm [16];
    if (!rstn[d]) begin
      m_n[d] = 0;
      e_ps = 1'b0;
      for (int ch = 0; ch < 16; ch++) begin
        m_lvl[d][ch] = C_INIT[d]; m_duty[d][ch] = 0;
        m_sa[d][ch] = '0; m_sb[d][ch] = '0; m_da[d][ch] = 0; m_db[d][ch] = 0;
        m_ha[d][ch] = '0; m_hb[d][ch] = '0; e_pwm[ch] = 1'b0;
      end
    end else begin
      m_n[d]++;
      e_ps = ((m_n[d] - 1) % p == 0);
      for (int ch = 0; ch < C_NCH[d]; ch++) begin
        e_pwm[ch] = ((m_n[d] - 1) % p) < m_duty[d][ch];
        if (m_n[d] % p == 0) m_duty[d][ch] = m_lvl[d][ch];
        begin
          int oa = 0, ob = 0;
          m_sa[d][ch] = {m_sa[d][ch][14:0], pa[d][ch]};
          m_sb[d][ch] = {m_sb[d][ch][14:0], pb[d][ch]};
          // A pin edge needs 2 sync cycles, then DB_LEN agreeing samples.
          for (int k = 2; k <= C_DB[d] + 1; k++) begin
            oa += m_sa[d][ch][k];
            ob += m_sb[d][ch][k];
          end
          if (oa == C_DB[d]) m_da[d][ch] = 1; else if (oa == 0) m_da[d][ch] = 0;
          if (ob == C_DB[d]) m_db[d][ch] = 1; else if (ob == 0) m_db[d][ch] = 0;
        end
        m_ha[d][ch] = {m_ha[d][ch][2:0], m_da[d][ch]};
        m_hb[d][ch] = {m_hb[d][ch][2:0], m_db[d][ch]};
        // A debounced A rise two edges back is applied now.
        if (m_ha[d][ch][2] && !m_ha[d][ch][3])
          m_lvl[d][ch] = step_level(d, m_lvl[d][ch], m_hb[d][ch][2]);
      end
    end
    check($sformatf("ps d%0d", d), 32'(ps_v[d]), 32'(e_ps));
    for (int ch = 0; ch < C_NCH[d]; ch++) begin
      check($sformatf("level d%0d ch%0d", d, ch), 32'(get_level(d, ch)), 32'(m_lvl[d][ch]));
      check($sformatf("pwm d%0d ch%0d", d, ch), 32'(get_pwm(d, ch)), 32'(e_pwm[ch]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      model_and_compare(d);
      if (ps_v[d]) begin
        per_last[d] = per_acc[d]; per_acc[d] = 1;
      end else begin
        per_acc[d]++;
      end
      for (int ch = 0; ch < C_NCH[d]; ch++) begin
        if (ps_v[d]) begin
          hi_last[d][ch] = hi_acc[d][ch]; hi_acc[d][ch] = int'(get_pwm(d, ch));
        end else begin
          hi_acc[d][ch] += int'(get_pwm(d, ch));
        end
      end
    end
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic detent(int d, logic [15:0] mask, bit down);
    pb[d] = down ? (pb[d] | mask) : (pb[d] & ~mask);
    ticks(C_DB[d] + 3);
    pa[d] = pa[d] | mask;
    ticks(C_DB[d] + 4);
    pa[d] = pa[d] & ~mask;
    ticks(C_DB[d] + 4);
  endtask

  task automatic wait_ps(int d);
    int k;
    for (k = 0; k < 300; k++) begin
      tick();
      if (ps_v[d]) break;
    end
    check($sformatf("ps_timeout d%0d", d), 32'(k < 300), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_left [ND];
    for (int d = 0; d < ND; d++) begin
      rstn[d] = 1'b0; pa[d] = '0; pb[d] = '0; rst_left[d] = 0;
      per_acc[d] = 0; per_last[d] = 0;
      for (int ch = 0; ch < 16; ch++) begin hi_acc[d][ch] = 0; hi_last[d][ch] = 0; end
    end

    // Reset held with pins toggling.
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < ND; d++) begin pa[d] = 16'($urandom); pb[d] = 16'($urandom); end
      tick();
    end
    check("rst_lv0", 32'(lv0), 32'd0);
    check("rst_pw0", 32'(pw0), 32'd0);
    check("rst_ps0", 32'(ps_v[0]), 32'd0);
    check("rst_lv1", 32'(lv1), 32'hFAFA);
    check("rst_lv3", 32'(lv3), 32'h33333);
    for (int d = 0; d < ND; d++) begin pa[d] = '0; pb[d] = '0; rstn[d] = 1'b1; end
    tick();
    check("first_ps", 32'(ps_v[0]), 32'd1);
    check("first_pw0", 32'(pw0), 32'd0);
    ticks(10);

    // Channel 0 latency: pin edge to level is 2 + DB_LEN + 2 edges.
    pa[0][0] = 1'b1;
    ticks(7);
    check("lat_before", 32'(lv0[7:0]), 32'd0);
    tick();
    check("lat_at", 32'(lv0[7:0]), 32'd1);
    pa[0][0] = 1'b0; ticks(8);
    pb[0][0] = 1'b1; ticks(8);
    pa[0][0] = 1'b1; ticks(8);
    check("ch0_down", 32'(lv0[7:0]), 32'd0);
    pa[0][0] = 1'b0; pb[0][0] = 1'b0; ticks(10);

    // Saturating arithmetic, STEP 10 from 250.
    detent(1, 16'h1, 1'b0);
    check("sat_up1", 32'(lv1[7:0]), 32'd255);
    detent(1, 16'h1, 1'b0);
    check("sat_up2", 32'(lv1[7:0]), 32'd255);
    for (int i = 0; i < 25; i++) detent(1, 16'h1, 1'b1);
    check("sat_dn_to5", 32'(lv1[7:0]), 32'd5);
    detent(1, 16'h1, 1'b1);
    check("sat_dn_0", 32'(lv1[7:0]), 32'd0);
    check("sat_ch1_idle", 32'(lv1[15:8]), 32'd250);

    // Wrapping arithmetic and glitch rejection.
    detent(2, 16'h1, 1'b0);
    check("wrap_up", 32'(lv2), 32'd0);
    detent(2, 16'h1, 1'b1);
    check("wrap_dn", 32'(lv2), 32'd255);
    pa[2][0] = 1'b1; ticks(3);
    pa[2][0] = 1'b0; ticks(12);
    check("glitch", 32'(lv2), 32'd255);

    // Double-buffered duty: mid-period change applies next period only.
    for (int i = 0; i < 64; i++) detent(0, 16'h2, 1'b0);
    check("load64", 32'(lv0[15:8]), 32'd64);
    wait_ps(0);
    ticks(40);
    pa[0][1] = 1'b1; ticks(8);
    check("mid65", 32'(lv0[15:8]), 32'd65);
    pa[0][1] = 1'b0;
    wait_ps(0);
    check("period_len", 32'(per_last[0]), 32'd256);
    check("hi_cur64", 32'(hi_last[0][1]), 32'd64);
    check("hi_ch0", 32'(hi_last[0][0]), 32'd0);
    check("hi_ch2", 32'(hi_last[0][2]), 32'd0);
    wait_ps(0);
    check("hi_next65", 32'(hi_last[0][1]), 32'd65);

    // Five channels, 4-bit: simultaneous detents, short period, async reset.
    pa[3][4:0] = 5'h1f;
    ticks(5);
    check("multi_before", 32'(lv3), 32'h33333);
    tick();
    check("multi_at", 32'(lv3), 32'h44444);
    pa[3] = '0;
    wait_ps(3);
    wait_ps(3);
    check("w4_period", 32'(per_last[3]), 32'd16);
    check("w4_hi", 32'(hi_last[3][4]), 32'd4);
    tick();
    check("w4_pw_high", 32'(pw3), 32'h1f);
    rstn[3] = 1'b0;
    #1;
    check("async_pw", 32'(pw3), 32'd0);
    check("async_lv", 32'(lv3), 32'h33333);
    check("async_ps", 32'(ps_v[3]), 32'd0);
    ticks(2);
    rstn[3] = 1'b1;
    ticks(3);

    // Random phase: toggling pins (with glitches) and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int d = 0; d < ND; d++) begin
        if (rst_left[d] > 0) begin
          rst_left[d]--;
          if (rst_left[d] == 0) rstn[d] = 1'b1;
        end else if ($urandom_range(0, 799) == 0) begin
          rstn[d] = 1'b0;
          rst_left[d] = $urandom_range(1, 3);
        end
        for (int ch = 0; ch < C_NCH[d]; ch++) begin
          if ($urandom_range(0, 5) == 0) pa[d][ch] = ~pa[d][ch];
          if ($urandom_range(0, 9) == 0) pb[d][ch] = ~pb[d][ch];
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
